cmd_frame_builder: RTL and testbench

Command-path stage that sits directly upstream of the parallel-to-serial converter on the SD CMD line. It accepts a 6-bit command index and a 32-bit argument, and computes CRC7 bit-serially. It then presents the complete 48-bit command frame on oParallel with a one-cycle load strobe, and waits for the serializer's iComplete before accepting the next command.

---
 rtl/cmd_frame_builder_if.sv | 38 +++
 rtl/cmd_frame_builder.sv | 145 ++++++++++++++
 tb/tb_cmd_frame_builder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_frame_builder_if.sv
// cmd_frame_builder_if
//   Bundles the command request side and the serializer side of the SD
//   command frame builder.
//   master : command source / serializer model (drives requests, iComplete)
//   slave  : cmd_frame_builder
//   Signals:
//     iEnable    global advance enable
//     iStrobe    command request
//     iIndex     6-bit command index
//     iArgument  32-bit command argument
//     iComplete  serializer finished shifting the frame
//     oParallel  48-bit assembled frame
//     oLoad_send one-cycle load strobe for the serializer
//     oBusy      builder not idle
//     oDone      one-cycle pulse on successful transmission
//     oError     one-cycle pulse on transmit timeout
interface cmd_frame_builder_if;
  logic        iEnable;
  logic        iStrobe;
  logic [5:0]  iIndex;
  logic [31:0] iArgument;
  logic        iComplete;
  logic [47:0] oParallel;
  logic        oLoad_send;
  logic        oBusy;
  logic        oDone;
  logic        oError;

  modport master (
    output iEnable, iStrobe, iIndex, iArgument, iComplete,
    input  oParallel, oLoad_send, oBusy, oDone, oError
  );

  modport slave (
    input  iEnable, iStrobe, iIndex, iArgument, iComplete,
    output oParallel, oLoad_send, oBusy, oDone, oError
  );
endinterface

// File: rtl/cmd_frame_builder.sv
// cmd_frame_builder
//   Builds a 48-bit SD command frame {0,1,index,argument,crc7,1}, computing
//   CRC7 (x^7+x^3+1) one bit per enabled clock, hands the frame to the
//   serializer with a one-cycle load strobe and waits for its completion
//   or a timeout.
//   Ports:
//     iClock_SD  SD clock, all state on rising edge
//     iReset     asynchronous active-high reset
//     bus        cmd_frame_builder_if.slave (request, frame and status)
//   Parameter:
//     TX_TIMEOUT clocks allowed in WAIT_TX before aborting (1..255)
module cmd_frame_builder #(
  parameter int unsigned TX_TIMEOUT = 100
) (
  input  logic                 iClock_SD,
  input  logic                 iReset,
  cmd_frame_builder_if.slave   bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CRC_CALC = 3'd1;
  localparam logic [2:0] ST_LOAD     = 3'd2;
  localparam logic [2:0] ST_WAIT_TX  = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // Counter value on the clock that makes the count reach TX_TIMEOUT.
  localparam logic [7:0] TOUT_LAST = 8'(TX_TIMEOUT - 1);

  // One CRC7 step for a single message bit, MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = crc[6] ^ bit_in;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  logic [2:0]  state_r,    state_s;
  logic [39:0] shift_r,    shift_s;
  logic [6:0]  crc_r,      crc_s;
  logic [5:0]  bit_cnt_r,  bit_cnt_s;
  logic [7:0]  tout_r,     tout_s;
  logic [47:0] parallel_r, parallel_s;
  logic        load_r,     load_s;
  logic        busy_r,     busy_s;
  logic        done_r,     done_s;
  logic        error_r,    error_s;

  // Next-state and next-output logic; nothing advances while iEnable is low.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    crc_s      = crc_r;
    bit_cnt_s  = bit_cnt_r;
    tout_s     = tout_r;
    parallel_s = parallel_r;
    load_s     = 1'b0;
    done_s     = 1'b0;
    error_s    = 1'b0;
    if (bus.iEnable) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.iStrobe) begin
            shift_s   = {1'b0, 1'b1, bus.iIndex, bus.iArgument};
            crc_s     = 7'h00;
            bit_cnt_s = 6'd0;
            state_s   = ST_CRC_CALC;
          end else begin
            state_s   = ST_IDLE;
          end
        end
        ST_CRC_CALC: begin
          // Rotate rather than shift so the payload is intact after 40 bits.
          crc_s   = crc7_step(crc_r, shift_r[39]);
          shift_s = {shift_r[38:0], shift_r[39]};
          if (bit_cnt_r == 6'd39) begin
            state_s = ST_LOAD;
          end else begin
            bit_cnt_s = bit_cnt_r + 6'd1;
          end
        end
        ST_LOAD: begin
          parallel_s = {shift_r, crc_r, 1'b1};
          load_s     = 1'b1;
          tout_s     = 8'd0;
          state_s    = ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          // Completion has priority over a timeout on the same clock.
          if (bus.iComplete) begin
            state_s = ST_DONE;
          end else if (tout_r == TOUT_LAST) begin
            tout_s  = tout_r + 8'd1;
            error_s = 1'b1;
            state_s = ST_IDLE;
          end else begin
            tout_s  = tout_r + 8'd1;
          end
        end
        ST_DONE: begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    busy_s = (state_s != ST_IDLE);
  end

  // State and registered outputs with asynchronous reset.
  always_ff @(posedge iClock_SD or posedge iReset) begin
    if (iReset) begin
      state_r    <= ST_IDLE;
      shift_r    <= 40'h0;
      crc_r      <= 7'h00;
      bit_cnt_r  <= 6'd0;
      tout_r     <= 8'd0;
      parallel_r <= 48'h0;
      load_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      crc_r      <= crc_s;
      bit_cnt_r  <= bit_cnt_s;
      tout_r     <= tout_s;
      parallel_r <= parallel_s;
      load_r     <= load_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      error_r    <= error_s;
    end
  end

  assign bus.oParallel  = parallel_r;
  assign bus.oLoad_send = load_r;
  assign bus.oBusy      = busy_r;
  assign bus.oDone      = done_r;
  assign bus.oError     = error_r;

endmodule

// File: tb/tb_cmd_frame_builder.sv
// tb_cmd_frame_builder
//   Self-checking bench for cmd_frame_builder. Expected frames come from a
//   polynomial long-division CRC7 model; expected timing from the cycle
//   rules of the block (load 41 enabled clocks after capture, timeout after
//   TX_TIMEOUT clocks in WAIT_TX, done one clock after iComplete).
module tb_cmd_frame_builder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cmd_frame_builder_if bus ();

  cmd_frame_builder #(.TX_TIMEOUT(100)) dut (
    .iClock_SD (clk),
    .iReset    (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CRC7 as the remainder of msg * x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] model_crc(input logic [39:0] msg);
    logic [46:0] v;
    v = {msg, 7'h00};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) v = v ^ (47'h89 << (i - 7));
    end
    return v[6:0];
  endfunction

  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] msg;
    msg = {2'b01, idx, arg};
    return {msg, model_crc(msg), 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command; returns clocks from capture to oLoad_send and the frame.
  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input int freeze_at, input int freeze_len,
                          input int strobe2_at, input bit cmp_in_load,
                          output int lat, output logic [47:0] frame);
    bus.iEnable   = 1'b1;
    bus.iIndex    = idx;
    bus.iArgument = arg;
    bus.iStrobe   = 1'b1;
    tick();
    bus.iStrobe   = 1'b0;
    bus.iIndex    = 6'($urandom);
    bus.iArgument = $urandom;
    lat   = 0;
    frame = 48'h0;
    for (int c = 1; c <= 300; c++) begin
      if (c == freeze_at) bus.iEnable = 1'b0;
      if (c == freeze_at + freeze_len) bus.iEnable = 1'b1;
      bus.iStrobe = (c == strobe2_at);
      if (c == strobe2_at) bus.iIndex = 6'd17;
      bus.iComplete = cmp_in_load && (c == 41);
      tick();
      bus.iStrobe   = 1'b0;
      bus.iComplete = 1'b0;
      if (bus.oLoad_send) begin
        lat   = c;
        frame = bus.oParallel;
        break;
      end
    end
    bus.iEnable = 1'b1;
  endtask

  // Run the WAIT_TX phase; cycle numbers are relative to the oLoad_send clock.
  task automatic finish_tx(input int delay, input int window, input int strobe_at,
                           output int done_at, output int n_done,
                           output int err_at, output int n_err, output int n_load);
    done_at = 0; n_done = 0; err_at = 0; n_err = 0; n_load = 0;
    for (int c = 1; c <= window; c++) begin
      bus.iComplete = (c == delay);
      bus.iStrobe   = (c == strobe_at);
      if (c == strobe_at) bus.iIndex = 6'd17;
      tick();
      if (bus.oDone)      begin n_done++; if (done_at == 0) done_at = c; end
      if (bus.oError)     begin n_err++;  if (err_at == 0)  err_at = c;  end
      if (bus.oLoad_send) n_load++;
    end
    bus.iComplete = 1'b0;
    bus.iStrobe   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iEnable = 1'b0; bus.iStrobe = 1'b0; bus.iIndex = 6'd0;
    bus.iArgument = 32'h0; bus.iComplete = 1'b0;
    tick(); tick();
    checks++; if (bus.oParallel !== 48'h0) begin failures++; $display("FAIL reset_parallel got=%h want=%h", bus.oParallel, 48'h0); end
    checks++; if (bus.oLoad_send !== 1'b0) begin failures++; $display("FAIL reset_load got=%b want=0", bus.oLoad_send); end
    checks++; if (bus.oBusy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.oBusy); end
    checks++; if (bus.oDone !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.oDone); end
    checks++; if (bus.oError !== 1'b0) begin failures++; $display("FAIL reset_error got=%b want=0", bus.oError); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_known_cmds();
    logic [5:0]  idx_t [3];
    logic [31:0] arg_t [3];
    logic [47:0] frm_t [3];
    int lat, done_at, n_done, err_at, n_err, n_load;
    logic [47:0] frame;
    idx_t = '{6'd0, 6'd8, 6'd17};
    arg_t = '{32'h0, 32'h000001AA, 32'h0};
    frm_t = '{48'h400000000095, 48'h48000001AA87, 48'h510000000055};
    for (int k = 0; k < 3; k++) begin
      send_cmd(idx_t[k], arg_t[k], 0, 0, 0, 1'b0, lat, frame);
      checks++; if (frame !== frm_t[k]) begin failures++; $display("FAIL known_frame[%0d] got=%h want=%h", k, frame, frm_t[k]); end
      checks++; if (lat !== 41) begin failures++; $display("FAIL known_latency[%0d] got=%0d want=41", k, lat); end
      checks++; if (bus.oBusy !== 1'b1) begin failures++; $display("FAIL known_busy[%0d] got=%b want=1", k, bus.oBusy); end
      finish_tx(48, 60, 0, done_at, n_done, err_at, n_err, n_load);
      checks++; if (n_done !== 1 || done_at !== 49) begin failures++; $display("FAIL known_done[%0d] count=%0d at=%0d want count=1 at=49", k, n_done, done_at); end
      checks++; if (n_err !== 0 || n_load !== 0) begin failures++; $display("FAIL known_extra[%0d] err=%0d load=%0d want 0/0", k, n_err, n_load); end
      checks++; if (bus.oBusy !== 1'b0) begin failures++; $display("FAIL known_idle[%0d] busy=%b want=0", k, bus.oBusy); end
      checks++; if (bus.oParallel !== frm_t[k]) begin failures++; $display("FAIL known_hold[%0d] got=%h want=%h", k, bus.oParallel, frm_t[k]); end
    end
  endtask

  task automatic test_random();
    int lat, done_at, n_done, err_at, n_err, n_load, fz_at, fz_len, dly;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] frame;
    for (int k = 0; k < 10; k++) begin
      idx    = 6'($urandom);
      arg    = $urandom;
      fz_at  = int'($urandom_range(2, 35));
      fz_len = int'($urandom_range(0, 12));
      dly    = int'($urandom_range(1, 99));
      send_cmd(idx, arg, fz_at, fz_len, 0, 1'b0, lat, frame);
      checks++; if (frame !== model_frame(idx, arg)) begin failures++; $display("FAIL rand_frame[%0d] got=%h want=%h", k, frame, model_frame(idx, arg)); end
      checks++; if (lat !== 41 + fz_len) begin failures++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", k, lat, 41 + fz_len); end
      finish_tx(dly, dly + 4, 0, done_at, n_done, err_at, n_err, n_load);
      checks++; if (n_done !== 1 || done_at !== dly + 1 || n_err !== 0) begin failures++; $display("FAIL rand_done[%0d] count=%0d at=%0d err=%0d want 1 at %0d err 0", k, n_done, done_at, n_err, dly + 1); end
    end
  endtask

  task automatic test_timeout();
    int lat, done_at, n_done, err_at, n_err, n_load;
    logic [47:0] frame;
    send_cmd(6'd0, 32'h0, 0, 0, 0, 1'b0, lat, frame);
    finish_tx(0, 110, 0, done_at, n_done, err_at, n_err, n_load);
    checks++; if (n_err !== 1 || err_at !== 100) begin failures++; $display("FAIL timeout_error count=%0d at=%0d want 1 at 100", n_err, err_at); end
    checks++; if (n_done !== 0) begin failures++; $display("FAIL timeout_nodone got=%0d want=0", n_done); end
    checks++; if (bus.oBusy !== 1'b0) begin failures++; $display("FAIL timeout_idle busy=%b want=0", bus.oBusy); end
    // iComplete on the clock where the count would reach TX_TIMEOUT.
    send_cmd(6'd0, 32'h0, 0, 0, 0, 1'b0, lat, frame);
    finish_tx(100, 110, 0, done_at, n_done, err_at, n_err, n_load);
    checks++; if (n_done !== 1 || done_at !== 101) begin failures++; $display("FAIL tie_done count=%0d at=%0d want 1 at 101", n_done, done_at); end
    checks++; if (n_err !== 0) begin failures++; $display("FAIL tie_noerror got=%0d want=0", n_err); end
  endtask

  task automatic test_complete_in_load();
    int lat, done_at, n_done, err_at, n_err, n_load;
    logic [47:0] frame;
    send_cmd(6'd8, 32'h000001AA, 0, 0, 0, 1'b1, lat, frame);
    finish_tx(30, 40, 0, done_at, n_done, err_at, n_err, n_load);
    checks++; if (n_done !== 1 || done_at !== 31) begin failures++; $display("FAIL load_complete_ignored count=%0d at=%0d want 1 at 31", n_done, done_at); end
  endtask

  task automatic test_enable_gating();
    int lat, done_at, n_done, err_at, n_err, n_load;
    logic [47:0] frame;
    send_cmd(6'd0, 32'h0, 10, 10, 0, 1'b0, lat, frame);
    checks++; if (lat !== 51) begin failures++; $display("FAIL gate_latency got=%0d want=51", lat); end
    checks++; if (frame !== 48'h400000000095) begin failures++; $display("FAIL gate_frame got=%h want=%h", frame, 48'h400000000095); end
    finish_tx(20, 30, 0, done_at, n_done, err_at, n_err, n_load);
    checks++; if (n_done !== 1) begin failures++; $display("FAIL gate_done got=%0d want=1", n_done); end
  endtask

  task automatic test_strobe_busy();
    int lat, done_at, n_done, err_at, n_err, n_load;
    logic [47:0] frame;
    send_cmd(6'd0, 32'h0, 0, 0, 15, 1'b0, lat, frame);
    checks++; if (frame !== 48'h400000000095 || lat !== 41) begin failures++; $display("FAIL busy_first frame=%h lat=%0d want 400000000095 lat 41", frame, lat); end
    finish_tx(48, 70, 10, done_at, n_done, err_at, n_err, n_load);
    checks++; if (n_load !== 0 || n_done !== 1) begin failures++; $display("FAIL busy_ignored loads=%0d done=%0d want 0/1", n_load, n_done); end
    checks++; if (bus.oBusy !== 1'b0) begin failures++; $display("FAIL busy_idle busy=%b want=0", bus.oBusy); end
  endtask

  task automatic test_reset_mid();
    int lat, n_load;
    logic [47:0] frame;
    bus.iIndex = 6'd0; bus.iArgument = 32'h0; bus.iStrobe = 1'b1;
    tick();
    bus.iStrobe = 1'b0;
    repeat (20) tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.oParallel !== 48'h0 || bus.oBusy !== 1'b0 || bus.oLoad_send !== 1'b0) begin failures++; $display("FAIL midreset_outputs par=%h busy=%b load=%b want 0/0/0", bus.oParallel, bus.oBusy, bus.oLoad_send); end
    #3 rst = 1'b0;
    n_load = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus.oLoad_send) n_load++;
    end
    checks++; if (n_load !== 0 || bus.oBusy !== 1'b0) begin failures++; $display("FAIL midreset_noload loads=%0d busy=%b want 0/0", n_load, bus.oBusy); end
    send_cmd(6'd17, 32'h0, 0, 0, 0, 1'b0, lat, frame);
    checks++; if (frame !== 48'h510000000055) begin failures++; $display("FAIL midreset_cmd17 got=%h want=%h", frame, 48'h510000000055); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_known_cmds();
    test_random();
    test_timeout();
    test_complete_in_load();
    test_enable_gating();
    test_strobe_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
